// File: rtl/main_memory_port_pkg.sv
// Shared memory package: line/address types, MESI field type and port FSM states.
// Lines are LINE_W bits: [65:64] MESI state, [63:0] data.
package main_memory_port_pkg;

    localparam int MM_ADDR_W = 8;
    localparam int LINE_W    = 66;

    typedef logic [MM_ADDR_W-1:0] Taddress;
    typedef logic [LINE_W-1:0]    Tline;

    typedef enum logic [1:0] {
        MESI_I = 2'b00,
        MESI_S = 2'b01,
        MESI_E = 2'b10,
        MESI_M = 2'b11
    } Tmesi_state;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        READ,
        WRITE,
        DONE
    } mm_state_t;

    function automatic Tmesi_state line_mesi(input Tline l);
        return Tmesi_state'(l[65:64]);
    endfunction

endpackage

// File: rtl/main_memory_port_if.sv
// Request/response bundle between the memory controller (master) and the
// main-memory port (slave): mm_req/mm_we/mm_addr/mm_wline in, busy/read_line/pulses out.
interface main_memory_port_if #(
    parameter int ADDR_W = 8,
    parameter int LINE_W = 66
);

    logic              mm_req;
    logic              mm_we;
    logic [ADDR_W-1:0] mm_addr;
    logic [LINE_W-1:0] mm_wline;
    logic              mm_busy;
    logic [LINE_W-1:0] read_line;
    logic              read_mm_completed;
    logic              write_mm_completed;

    modport master (
        output mm_req,
        output mm_we,
        output mm_addr,
        output mm_wline,
        input  mm_busy,
        input  read_line,
        input  read_mm_completed,
        input  write_mm_completed
    );

    modport slave (
        input  mm_req,
        input  mm_we,
        input  mm_addr,
        input  mm_wline,
        output mm_busy,
        output read_line,
        output read_mm_completed,
        output write_mm_completed
    );

endinterface

// File: rtl/main_memory_port_mm_line_array.sv
// Single-port DEPTH x LINE_W line storage: synchronous write, combinational read.
// Ports: clk, we, addr, wdata in; rdata out (array[addr]).
module mm_line_array #(
    parameter int ADDR_W = 8,
    parameter int LINE_W = 66
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [LINE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/main_memory_port.sv
// Main-memory port: fixed-latency line reads/writes with one-cycle done pulses,
// hardware clear after reset. Ports: clk, reset (sync, active-high), mm (slave bundle).
module main_memory_port #(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 4,
    parameter int WR_LAT = 3,
    parameter int LINE_W = 66
) (
    input  logic              clk,
    input  logic              reset,
    main_memory_port_if.slave mm
);

    import main_memory_port_pkg::*;

    localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    if (RD_LAT < 1) begin : g_bad_rd_lat
        $error("RD_LAT must be at least 1");
    end
    if (WR_LAT < 1) begin : g_bad_wr_lat
        $error("WR_LAT must be at least 1");
    end
    if (LINE_W != main_memory_port_pkg::LINE_W) begin : g_bad_line_w
        $error("LINE_W must match the package line width");
    end

    mm_state_t         state;
    mm_state_t         state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] clr_ptr;
    logic              op_we;
    logic [ADDR_W-1:0] op_addr;
    logic [LINE_W-1:0] op_wline;
    logic [LINE_W-1:0] rd_q;

    logic              arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [LINE_W-1:0] arr_wdata;
    logic [LINE_W-1:0] arr_rdata;

    logic              accept;
    logic              cnt_zero;
    logic              clr_last;

    // A request held across DONE is taken at the edge that ends DONE, so
    // back-to-back operations do not lose a cycle passing through IDLE.
    assign accept   = mm.mm_req && (state == IDLE || state == DONE);
    assign cnt_zero = (cnt == '0);
    assign clr_last = (clr_ptr == '1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            CLEAR: begin
                if (clr_last) begin
                    state_nxt = IDLE;
                end
            end
            IDLE, DONE: begin
                if (accept) begin
                    state_nxt = mm.mm_we ? WRITE : READ;
                end else begin
                    state_nxt = IDLE;
                end
            end
            READ, WRITE: begin
                if (cnt_zero) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    // Counter holds the remaining busy cycles minus one; DONE follows at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_ptr  <= '0;
            cnt      <= '0;
            op_we    <= 1'b0;
            op_addr  <= '0;
            op_wline <= '0;
            rd_q     <= '0;
        end else begin
            if (state == CLEAR) begin
                clr_ptr <= clr_ptr + 1'b1;
            end
            if (accept) begin
                op_we    <= mm.mm_we;
                op_addr  <= mm.mm_addr;
                op_wline <= mm.mm_wline;
                cnt      <= mm.mm_we ? CNT_W'(WR_LAT - 1)
                                     : CNT_W'(RD_LAT - 1);
            end else if ((state == READ || state == WRITE) && !cnt_zero) begin
                cnt <= cnt - 1'b1;
            end
            if (state == READ && cnt_zero) begin
                rd_q <= arr_rdata;
            end
        end
    end

    // Array writes are gated by reset so an aborted write never commits.
    always_comb begin
        mm.mm_busy            = (state != IDLE);
        mm.read_mm_completed  = (state == DONE) && !op_we;
        mm.write_mm_completed = (state == DONE) && op_we;
        arr_we                = 1'b0;
        arr_addr              = op_addr;
        arr_wdata             = op_wline;
        if (!reset) begin
            if (state == CLEAR) begin
                arr_we    = 1'b1;
                arr_addr  = clr_ptr;
                arr_wdata = '0;
            end else if (state == WRITE && cnt_zero) begin
                arr_we = 1'b1;
            end
        end
    end

    assign mm.read_line = rd_q;

    mm_line_array #(
        .ADDR_W(ADDR_W),
        .LINE_W(LINE_W)
    ) u_array (
        .clk  (clk),
        .we   (arr_we),
        .addr (arr_addr),
        .wdata(arr_wdata),
        .rdata(arr_rdata)
    );

endmodule

// File: tb/tb_main_memory_port.sv
// Directed bench for main_memory_port: clear length, latencies, pulses,
// held requests, back-to-back ops and reset during a write.
module tb_main_memory_port;

    import main_memory_port_pkg::*;

    localparam logic [65:0] L1 = 66'h2_DEAD_BEEF_0123_4567;
    localparam logic [65:0] L2 = 66'h1_0F0F_1234_5678_9ABC;
    localparam logic [65:0] L3 = 66'h3_CAFE_F00D_AAAA_5555;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    main_memory_port_if #(.ADDR_W(8), .LINE_W(66)) mm_bus();

    main_memory_port #(
        .ADDR_W(8),
        .RD_LAT(4),
        .WR_LAT(3),
        .LINE_W(66)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .mm   (mm_bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [65:0] got,
                         input logic [65:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Entered in the first cycle with reset low; leaves in the first IDLE cycle.
    task automatic wait_clear();
        int   n;
        logic pulse_seen;
        n          = 0;
        pulse_seen = 1'b0;
        while (mm_bus.mm_busy && n < 1000) begin
            if (mm_bus.read_mm_completed || mm_bus.write_mm_completed)
                pulse_seen = 1'b1;
            n++;
            tick();
        end
        check("clear_len", 66'(n), 66'd256);
        check("clear_pulse", 66'(pulse_seen), 66'd0);
    endtask

    // Called in an IDLE cycle; returns in the IDLE cycle after DONE.
    task automatic op(input logic we, input logic [7:0] a,
                      input logic [65:0] d, input logic [65:0] exp_rd,
                      input int lat);
        mm_bus.mm_req   = 1'b1;
        mm_bus.mm_we    = we;
        mm_bus.mm_addr  = a;
        mm_bus.mm_wline = d;
        tick();
        mm_bus.mm_req   = 1'b0;
        mm_bus.mm_we    = ~we;
        mm_bus.mm_addr  = ~a;
        mm_bus.mm_wline = ~d;
        for (int i = 0; i <= lat; i++) begin
            check("rd_pulse", 66'(mm_bus.read_mm_completed),
                  66'(!we && i == lat));
            check("wr_pulse", 66'(mm_bus.write_mm_completed),
                  66'(we && i == lat));
            check("busy", 66'(mm_bus.mm_busy), 66'd1);
            if (!we && i == lat)
                check("rd_line", mm_bus.read_line, exp_rd);
            tick();
        end
        check("idle_after", 66'(mm_bus.mm_busy), 66'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset           = 1'b1;
        mm_bus.mm_req   = 1'b0;
        mm_bus.mm_we    = 1'b0;
        mm_bus.mm_addr  = '0;
        mm_bus.mm_wline = '0;
        repeat (3) tick();
        check("rst_busy", 66'(mm_bus.mm_busy), 66'd1);
        check("rst_line", mm_bus.read_line, 66'd0);
        check("rst_rdp", 66'(mm_bus.read_mm_completed), 66'd0);
        check("rst_wrp", 66'(mm_bus.write_mm_completed), 66'd0);
        reset = 1'b0;
        wait_clear();

        op(1'b0, 8'h3F, 66'd0, 66'd0, 4);
        op(1'b1, 8'h12, L1, 66'd0, 3);
        op(1'b1, 8'h13, L2, 66'd0, 3);
        op(1'b0, 8'h12, 66'd0, L1, 4);
        check("rd_held", mm_bus.read_line, L1);
        check("mesi", 66'(line_mesi(mm_bus.read_line)), 66'(2'b10));

        // read 0x12 with mm_req held and the address moved to 0x13
        mm_bus.mm_req  = 1'b1;
        mm_bus.mm_we   = 1'b0;
        mm_bus.mm_addr = 8'h12;
        tick();
        mm_bus.mm_addr = 8'h13;
        for (int i = 0; i <= 4; i++) begin
            check("hold_busy", 66'(mm_bus.mm_busy), 66'd1);
            check("hold_rdp", 66'(mm_bus.read_mm_completed), 66'(i == 4));
            if (i == 4) check("hold_line1", mm_bus.read_line, L1);
            tick();
        end
        mm_bus.mm_req = 1'b0;
        for (int i = 0; i <= 4; i++) begin
            check("hold2_busy", 66'(mm_bus.mm_busy), 66'd1);
            check("hold2_rdp", 66'(mm_bus.read_mm_completed), 66'(i == 4));
            if (i == 4) check("hold_line2", mm_bus.read_line, L2);
            tick();
        end
        check("hold_idle", 66'(mm_bus.mm_busy), 66'd0);

        // write 0x05 then read 0x05 with mm_req never dropped
        mm_bus.mm_req   = 1'b1;
        mm_bus.mm_we    = 1'b1;
        mm_bus.mm_addr  = 8'h05;
        mm_bus.mm_wline = L3;
        tick();
        mm_bus.mm_we    = 1'b0;
        mm_bus.mm_wline = '0;
        for (int i = 0; i <= 3; i++) begin
            check("b2b_wrp", 66'(mm_bus.write_mm_completed), 66'(i == 3));
            check("b2b_rdp0", 66'(mm_bus.read_mm_completed), 66'd0);
            tick();
        end
        mm_bus.mm_req = 1'b0;
        for (int i = 0; i <= 4; i++) begin
            check("b2b_busy", 66'(mm_bus.mm_busy), 66'd1);
            check("b2b_rdp", 66'(mm_bus.read_mm_completed), 66'(i == 4));
            if (i == 4) check("b2b_line", mm_bus.read_line, L3);
            tick();
        end
        check("b2b_idle", 66'(mm_bus.mm_busy), 66'd0);

        // reset in c_{k+1} of a write to 0x20
        mm_bus.mm_req   = 1'b1;
        mm_bus.mm_we    = 1'b1;
        mm_bus.mm_addr  = 8'h20;
        mm_bus.mm_wline = 66'h1_FFFF;
        tick();
        mm_bus.mm_req = 1'b0;
        tick();
        reset = 1'b1;
        check("abort_wrp0", 66'(mm_bus.write_mm_completed), 66'd0);
        tick();
        check("abort_busy", 66'(mm_bus.mm_busy), 66'd1);
        check("abort_wrp1", 66'(mm_bus.write_mm_completed), 66'd0);
        check("abort_line", mm_bus.read_line, 66'd0);
        reset = 1'b0;
        wait_clear();
        op(1'b0, 8'h20, 66'd0, 66'd0, 4);
        op(1'b0, 8'h12, 66'd0, 66'd0, 4);
        op(1'b0, 8'h05, 66'd0, 66'd0, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
